// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared state encoding, default sizes and element-slice helper for the sort core
package sort_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_N = 4;
    localparam int DEF_W = 4;

    function automatic int elem_lsb(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// rtl/sort_cmp_swap.sv - one compare-and-swap stage; SORT_DESCEND_EN flips the order
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swapped
);

    // Strict comparison: equal values stay put, keeping the sort stable.
`ifdef SORT_DESCEND_EN
    assign swapped = (a < b);
`else
    assign swapped = (a > b);
`endif

    assign lo = swapped ? b : a;
    assign hi = swapped ? a : b;

endmodule

// File: rtl/bubble_sort_core.sv
// rtl/bubble_sort_core.sv - sequential bubble sort, one compare per clock, early exit on a clean pass
// Build option: SORT_DESCEND_EN selects descending order.
module bubble_sort_core
    import sort_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*W-1:0] uns_data,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] sort_data
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   arr      [N];
    logic [W-1:0]   arr_post [N];
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idx_inc;
    logic [IW-1:0]  pass;
    logic [IW-1:0]  pass_end;
    logic           swp;
    logic [W-1:0]   cmp_a;
    logic [W-1:0]   cmp_b;
    logic [W-1:0]   lo;
    logic [W-1:0]   hi;
    logic           swapped;
    logic           end_of_pass;
    logic           finish;

    assign idx_inc     = idx + IW'(1);
    assign cmp_a       = arr[idx];
    assign cmp_b       = arr[idx_inc];
    assign pass_end    = LAST_PASS - pass;
    assign end_of_pass = (idx >= pass_end);
    assign finish      = end_of_pass && (!(swp || swapped) || (pass == LAST_PASS));

    sort_cmp_swap #(.W(W)) u_cmp (
        .a       (cmp_a),
        .b       (cmp_b),
        .lo      (lo),
        .hi      (hi),
        .swapped (swapped)
    );

    always_comb begin
        arr_post          = arr;
        arr_post[idx]     = lo;
        arr_post[idx_inc] = hi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_SORT;
            ST_SORT: if (finish) state_nxt = ST_DONE;
            ST_DONE: state_nxt = start ? ST_SORT : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SORT);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                arr[i] <= '0;
            end
            idx       <= '0;
            pass      <= '0;
            swp       <= 1'b0;
            sort_data <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            arr[i] <= uns_data[elem_lsb(i, W) +: W];
                        end
                        idx  <= '0;
                        pass <= '0;
                        swp  <= 1'b0;
                    end
                end
                ST_SORT: begin
                    for (int i = 0; i < N; i++) begin
                        arr[i] <= arr_post[i];
                    end
                    if (!end_of_pass) begin
                        idx <= idx_inc;
                        swp <= swp | swapped;
                    end else if (finish) begin
                        // Publish the post-swap array so the final compare is included.
                        for (int i = 0; i < N; i++) begin
                            sort_data[elem_lsb(i, W) +: W] <= arr_post[i];
                        end
                    end else begin
                        pass <= pass + IW'(1);
                        idx  <= '0;
                        swp  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sort_core.sv
// tb/tb_bubble_sort_core.sv - directed self-checking bench for bubble_sort_core (N=4, W=4)
module tb_bubble_sort_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] uns_data = '0;
    logic        busy;
    logic        done;
    logic [15:0] sort_data;

    int checks   = 0;
    int failures = 0;
    int busy_bad = 0;
    int lat;
    int n_done;

    always #5 clk = ~clk;

    bubble_sort_core #(.N(4), .W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .uns_data  (uns_data),
        .busy      (busy),
        .done      (done),
        .sort_data (sort_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pk(input logic [3:0] e0, input logic [3:0] e1,
                                       input logic [3:0] e2, input logic [3:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic do_start(input logic [15:0] d);
        @(negedge clk);
        uns_data = d;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat_o);
        lat_o    = lat0;
        busy_bad = 0;
        while (lat_o < 40) begin
            @(posedge clk);
            #1;
            lat_o++;
            if (done) break;
            if (!busy) busy_bad++;
        end
        if (!done) lat_o = 99;
    endtask

    task automatic run_case(input string tag, input logic [15:0] d,
                            input logic [15:0] exp_data, input int exp_lat);
        int l;
        do_start(d);
        wait_done(0, l);
        check({tag, "_lat"}, l, exp_lat);
        check({tag, "_data"}, sort_data, exp_data);
        check({tag, "_busy"}, busy_bad, 0);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", sort_data, 16'h0);
        @(negedge clk);
        rst = 1'b0;

`ifdef SORT_DESCEND_EN
        run_case("rev", pk(4'h9, 4'h7, 4'h3, 4'h1), pk(4'h9, 4'h7, 4'h3, 4'h1), 3);
`else
        run_case("rev", pk(4'h9, 4'h7, 4'h3, 4'h1), pk(4'h1, 4'h3, 4'h7, 4'h9), 6);
`endif
        @(posedge clk);
        #1;
        check("done_width", done, 1'b0);
        check("idle_busy", busy, 1'b0);

        // Asynchronous reset in the middle of a sort.
        do_start(pk(4'h9, 4'h3, 4'h7, 4'h1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_data", sort_data, 16'h0);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        check("abort_data_held", sort_data, 16'h0);

`ifdef SORT_DESCEND_EN
        run_case("sorted", pk(4'h2, 4'h4, 4'h6, 4'h8), pk(4'h8, 4'h6, 4'h4, 4'h2), 6);
        run_case("dup", pk(4'hF, 4'h0, 4'hF, 4'h0), pk(4'hF, 4'hF, 4'h0, 4'h0), 5);
`else
        run_case("sorted", pk(4'h2, 4'h4, 4'h6, 4'h8), pk(4'h2, 4'h4, 4'h6, 4'h8), 3);
        run_case("dup", pk(4'hF, 4'h0, 4'hF, 4'h0), pk(4'h0, 4'h0, 4'hF, 4'hF), 6);
`endif
        run_case("same", pk(4'h5, 4'h5, 4'h5, 4'h5), pk(4'h5, 4'h5, 4'h5, 4'h5), 3);

        // Start pulse mid-sort with different data must be ignored.
        do_start(pk(4'h3, 4'h9, 4'h1, 4'h7));
        @(posedge clk);
        #1;
        uns_data = pk(4'hF, 4'hE, 4'hD, 4'hC);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mid_busy", busy, 1'b1);
        wait_done(2, lat);
`ifdef SORT_DESCEND_EN
        check("mid_lat", lat, 6);
        check("mid_data", sort_data, pk(4'h9, 4'h7, 4'h3, 4'h1));
`else
        check("mid_lat", lat, 6);
        check("mid_data", sort_data, pk(4'h1, 4'h3, 4'h7, 4'h9));
`endif

        // Back-to-back start during the done cycle.
        uns_data = pk(4'h8, 4'h1, 4'h4, 4'h2);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_done_low", done, 1'b0);
        wait_done(0, lat);
`ifdef SORT_DESCEND_EN
        check("b2b_lat", lat, 5);
        check("b2b_data", sort_data, pk(4'h8, 4'h4, 4'h2, 4'h1));
`else
        check("b2b_lat", lat, 6);
        check("b2b_data", sort_data, pk(4'h1, 4'h2, 4'h4, 4'h8));
`endif
        check("b2b_run_busy", busy_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
